// File: rtl/sop_defs.sv
// Shared encodings for the sum-of-products result path: serializer FSM
// states and bit-order selectors.
package sop_defs;

  typedef enum logic {
    SOP_SER_IDLE  = 1'b0,
    SOP_SER_SHIFT = 1'b1
  } sop_ser_state_e;

  localparam bit SOP_LSB_FIRST = 1'b0;
  localparam bit SOP_MSB_FIRST = 1'b1;

endpackage

// File: rtl/sop_result_serializer.sv
// Parallel-to-serial transmitter for the SOP result word: one load handshake,
// then DATA_WIDTH single-bit valid/ready transfers framed by first/last.
module sop_result_serializer
  import sop_defs::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = SOP_LSB_FIRST,
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  ser_first,
  output logic                  ser_last,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  sop_ser_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] shreg_shifted;

  assign shreg_shifted = (MSB_FIRST == SOP_MSB_FIRST)
                         ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                         : {1'b0, shreg_q[DATA_WIDTH-1:1]};

  assign xfer = (state_q == SOP_SER_SHIFT) && ser_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      SOP_SER_IDLE: begin
        if (load_valid) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = SOP_SER_SHIFT;
        end
      end
      SOP_SER_SHIFT: begin
        if (xfer) begin
          shreg_d = shreg_shifted;
          // Counter parks at its terminal value; the next load clears it.
          if (cnt_q == CNT_LAST) begin
            state_d = SOP_SER_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = SOP_SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SOP_SER_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // A completed frame leaves the register zero-filled, so ser_out idles low.
  assign ser_out    = (MSB_FIRST == SOP_MSB_FIRST) ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
  assign ser_valid  = (state_q == SOP_SER_SHIFT);
  assign busy       = (state_q == SOP_SER_SHIFT);
  assign load_ready = (state_q == SOP_SER_IDLE);
  assign ser_first  = (state_q == SOP_SER_SHIFT) && (cnt_q == '0);
  assign ser_last   = (state_q == SOP_SER_SHIFT) && (cnt_q == CNT_LAST);
  assign frame_done = done_q;

endmodule

// File: tb/tb_sop_result_serializer.sv
// Directed bench for sop_result_serializer: LSB-first table plus hand-written
// MSB-first, reset, and back-to-back sequences.
module tb_sop_result_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       lv0, rdy0, lv1, rdy1;
  logic [7:0] ld0, ld1;
  logic       lr0, so0, sv0, sf0, sl0, bz0, fd0;
  logic       lr1, so1, sv1, sf1, sl1, bz1, fd1;

  sop_result_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_data(ld0), .load_ready(lr0),
    .ser_out(so0), .ser_valid(sv0), .ser_ready(rdy0), .ser_first(sf0),
    .ser_last(sl0), .busy(bz0), .frame_done(fd0));

  sop_result_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_data(ld1), .load_ready(lr1),
    .ser_out(so1), .ser_valid(sv1), .ser_ready(rdy1), .ser_first(sf1),
    .ser_last(sl1), .busy(bz1), .frame_done(fd1));

  // Packed observation: {valid, out, first, last, done, load_ready, busy}
  typedef struct {
    logic       lv;
    logic [7:0] ld;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [6:0] obs0();
    return {sv0, so0, sf0, sl0, fd0, lr0, bz0};
  endfunction

  function automatic logic [6:0] obs1();
    return {sv1, so1, sf1, sl1, fd1, lr1, bz1};
  endfunction

  function automatic logic [6:0] sh(logic o, logic f, logic l);
    return {1'b1, o, f, l, 1'b0, 1'b0, 1'b1};
  endfunction

  function automatic logic [6:0] idle(logic d);
    return {1'b0, 1'b0, 1'b0, 1'b0, d, 1'b1, 1'b0};
  endfunction

  function automatic vec_t mk(logic lv, logic [7:0] ld, logic rdy, logic [6:0] e);
    vec_t v;
    v.lv = lv; v.ld = ld; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] b2b;
    logic [7:0] fr;

    rst = 1'b0; lv0 = 1'b0; ld0 = '0; rdy0 = 1'b1;
    lv1 = 1'b0; ld1 = '0; rdy1 = 1'b1;
    step(); step();
    chk("reset_dut0", obs0(), idle(1'b0));
    chk("reset_dut1", obs1(), idle(1'b0));
    rst = 1'b1;

    // Basic A5 frame
    w = 8'hA5;
    tbl.push_back(mk(1'b1, w, 1'b1, sh(w[0], 1'b1, 1'b0)));
    for (int i = 1; i < 8; i++) tbl.push_back(mk(1'b0, 8'h00, 1'b1, sh(w[i], 1'b0, i == 7)));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, idle(1'b1)));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, idle(1'b0)));
    // Backpressure: stall 3 cycles while bit 3 is presented
    tbl.push_back(mk(1'b1, w, 1'b1, sh(w[0], 1'b1, 1'b0)));
    for (int i = 1; i < 4; i++) tbl.push_back(mk(1'b0, 8'h00, 1'b1, sh(w[i], 1'b0, 1'b0)));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 8'h00, 1'b0, sh(w[3], 1'b0, 1'b0)));
    for (int i = 4; i < 8; i++) tbl.push_back(mk(1'b0, 8'h00, 1'b1, sh(w[i], 1'b0, i == 7)));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, idle(1'b1)));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, idle(1'b0)));
    // Load while busy is ignored
    tbl.push_back(mk(1'b1, w, 1'b1, sh(w[0], 1'b1, 1'b0)));
    for (int i = 1; i < 8; i++)
      tbl.push_back(mk(i == 3 || i == 4, 8'h3C, 1'b1, sh(w[i], 1'b0, i == 7)));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, idle(1'b1)));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, idle(1'b0)));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, idle(1'b0)));

    foreach (tbl[k]) begin
      lv0 = tbl[k].lv; ld0 = tbl[k].ld; rdy0 = tbl[k].rdy;
      step();
      chk($sformatf("table[%0d]", k), obs0(), tbl[k].exp);
    end
    lv0 = 1'b0; rdy0 = 1'b1;

    // MSB-first C1 on dut1
    w = 8'hC1;
    lv1 = 1'b1; ld1 = w;
    step();
    lv1 = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      chk($sformatf("msb_bit%0d", i), obs1(), sh(w[i], i == 7, i == 0));
      step();
    end
    chk("msb_done", obs1(), idle(1'b1));

    // Reset mid-frame after 4 transfers
    lv0 = 1'b1; ld0 = 8'hFF;
    step();
    lv0 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_before_rst", obs0(), sh(1'b1, 1'b0, 1'b0));
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_abort", obs0(), idle(1'b0));
    step();
    chk("mid_rst_no_done", obs0(), idle(1'b0));
    w = 8'h01;
    lv0 = 1'b1; ld0 = w;
    step();
    lv0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("after_rst_bit%0d", i), obs0(), sh(w[i], i == 0, i == 7));
      step();
    end
    chk("after_rst_done", obs0(), idle(1'b1));

    // Load and reset together: reset wins
    rst = 1'b0; lv0 = 1'b1; ld0 = 8'h55;
    step();
    rst = 1'b1; lv0 = 1'b0;
    chk("rst_load_same", obs0(), idle(1'b0));
    step();
    chk("rst_load_after", obs0(), idle(1'b0));

    // Back-to-back with load_valid held high
    lv0 = 1'b1; ld0 = 8'h0F;
    step();
    ld0 = 8'hF0;
    b2b = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_a_bit%0d", i), obs0(), sh(b2b[i], i == 0, i == 7));
      step();
    end
    chk("b2b_gap", obs0(), idle(1'b1));
    step();
    lv0 = 1'b0;
    b2b = 8'hF0;
    fr  = '0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_b_bit%0d", i), obs0(), sh(b2b[i], i == 0, i == 7));
      fr[i] = so0;
      step();
    end
    chk("b2b_b_done", obs0(), idle(1'b1));
    chk("b2b_b_word", {fr[6:0]}, b2b[6:0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sop_result_serializer.md
Name: sop_result_serializer

Overview:
- Parallel-to-serial transmitter for the sum-of-products datapath. It sits on the output side of the result register.
- Accepts one DATA_WIDTH-bit result word through a valid/ready load handshake, then sends it one bit per transfer on a serial valid/ready interface.
- Provides frame markers (first/last) and a one-cycle done pulse, so the downstream receiver can reassemble the word.

Parameters:
- DATA_WIDTH, 8, width of the result word; legal range >= 2.
- MSB_FIRST, 0, bit order: 0 sends bit 0 first, 1 sends bit DATA_WIDTH-1 first.
- CNT_WIDTH, $clog2(DATA_WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-low; rst==0 at a rising edge of clk resets the block.
- load_valid  input  1  load_data is valid.
- load_data  input  DATA_WIDTH  result word to send.
- load_ready  output  1  block can accept a word; high only in IDLE.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  downstream accepts the current bit.
- ser_first  output  1  current bit is the first bit of the frame.
- ser_last  output  1  current bit is the last bit of the frame.
- busy  output  1  a frame is in progress (state SHIFT).
- frame_done  output  1  one-cycle pulse after the last bit is transferred.

Behaviour:
- Reset values (rst==0 at a rising edge):
  - state=IDLE, shift register=0, bit counter=0, frame_done=0.
  - Resulting outputs: ser_valid=0, ser_out=0, ser_first=0, ser_last=0, busy=0, load_ready=1.
- FSM has two states, IDLE and SHIFT.
  - IDLE: load_ready=1. If load_valid=1 at an edge: capture load_data into the shift register, clear the counter, go to SHIFT.
  - SHIFT: ser_valid=1, busy=1, load_ready=0.
  - A bit transfers at an edge where ser_valid && ser_ready.
  - On a transfer: shift the register one position (right if MSB_FIRST=0, left if 1) and increment the counter.
  - On the transfer with counter==DATA_WIDTH-1: go to IDLE and assert frame_done for exactly the following cycle.
- Output derivation:
  - ser_out = shift register bit 0 (MSB_FIRST=0) or bit DATA_WIDTH-1 (MSB_FIRST=1). It is driven directly from registers, with no combinational path from any input.
  - ser_first = SHIFT && counter==0.
  - ser_last = SHIFT && counter==DATA_WIDTH-1.
- Latency:
  - Load accepted at edge N: first bit is valid in the cycle after N.
  - With ser_ready held high, the last bit transfers at edge N+DATA_WIDTH.
  - load_ready and frame_done are both high in the cycle after that edge. The minimum load-to-load spacing is DATA_WIDTH+1 cycles.
- Backpressure: while ser_ready=0, the shift register, counter, ser_out, ser_first and ser_last all hold. Stall length is unbounded.
- load_valid while busy is ignored: no capture, and the word in flight is not corrupted.
- Load and reset in the same cycle: reset wins, nothing is captured.
- Reset mid-frame: the frame is aborted at once with no partial continuation, and frame_done is not pulsed.
- Zero-valued word: sent as a normal full frame of DATA_WIDTH bits.
- Counter never wraps: it is reset on every load and DATA_WIDTH-1 is its terminal value.

Decomposition:
- Shared package/include sop_defs holds:
  - state encodings SOP_SER_IDLE=1'b0, SOP_SER_SHIFT=1'b1;
  - bit-order constants SOP_LSB_FIRST=0, SOP_MSB_FIRST=1.
- No sub-module. The counter and shift register are small enough to stay inline.
- The existing load-only register block is not reused, because the shift register needs load, shift and hold modes.

Test Plan:
- Basic frame: DATA_WIDTH=8, MSB_FIRST=0, ser_ready=1, load 8'hA5 at edge N.
  - ser_out = 1,0,1,0,0,1,0,1 in cycles N+1..N+8.
  - ser_first only in cycle N+1, ser_last only in cycle N+8.
  - frame_done=1 and load_ready=1 in cycle N+9.
- MSB-first frame: MSB_FIRST=1, load 8'hC1 → ser_out = 1,1,0,0,0,0,0,1.
- Backpressure: load 8'hA5, drop ser_ready for 3 cycles while bit 3 (value 0) is presented.
  - ser_out=0, ser_valid=1 and counter=3 hold throughout the stall.
  - The remaining bits 0,1,0,1 follow once ready returns; ser_last and frame_done are delayed by exactly 3 cycles.
- Load while busy: during a 8'hA5 frame, pulse load_valid with 8'h3C → frame still emits the 8'hA5 bit sequence, and 8'h3C is never transmitted.
- Reset mid-frame: load 8'hFF, drive rst=0 after 4 transfers.
  - The next cycle has ser_valid=0, busy=0, load_ready=1, frame_done=0.
  - A following load of 8'h01 emits 1,0,0,0,0,0,0,0 from a clean start.
- Back-to-back: hold load_valid=1 with 8'h0F then 8'hF0.
  - The second word is captured in the first IDLE cycle after frame_done of the first.
  - Exactly one idle cycle with ser_valid=0 between frames; 16 bits total, in order.
